// File: rtl/zero_scan_stream.sv
// Framed zero scanner: per frame reports all-zero flag, first non-zero index,
// non-zero word count and frame length, all saturating at 2^CNT_W-1.
module zero_scan_stream #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_zero,
  output logic [CNT_W-1:0] out_first_nz,
  output logic [CNT_W-1:0] out_nz_count,
  output logic [CNT_W-1:0] out_len,
  output logic             out_ovf
);

  typedef enum logic {ACC, DONE} state_t;

  localparam logic [CNT_W-1:0] MAX = '1;

  state_t           state, state_nxt;
  logic             all_zero, seen, ovf;
  logic [CNT_W-1:0] idx, first_nz, nz_count;

  logic             word_zero, accept, idx_at_max;
  logic             all_zero_n, seen_n, ovf_n;
  logic [CNT_W-1:0] idx_n, first_nz_n, nz_count_n;

  assign in_ready  = (state == ACC);
  assign out_valid = (state == DONE);
  assign word_zero = ~|in_data;
  assign accept    = in_valid && in_ready;

  // Accumulator update for the current word; idx_n doubles as the frame length
  // when the word is the last one.
  always_comb begin
    idx_at_max = (idx == MAX);
    all_zero_n = all_zero & word_zero;
    seen_n     = seen | ~word_zero;
    first_nz_n = (!seen && !word_zero) ? idx : first_nz;
    nz_count_n = (!word_zero && nz_count != MAX) ? nz_count + CNT_W'(1) : nz_count;
    idx_n      = idx_at_max ? idx : idx + CNT_W'(1);
    ovf_n      = ovf | idx_at_max;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACC:  if (accept && in_last) state_nxt = DONE;
      DONE: if (out_ready)         state_nxt = ACC;
      default:                     state_nxt = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ACC;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      all_zero     <= 1'b1;
      seen         <= 1'b0;
      ovf          <= 1'b0;
      idx          <= '0;
      first_nz     <= '0;
      nz_count     <= '0;
      out_zero     <= 1'b0;
      out_first_nz <= '0;
      out_nz_count <= '0;
      out_len      <= '0;
      out_ovf      <= 1'b0;
    end else if (accept) begin
      if (in_last) begin
        out_zero     <= all_zero_n;
        out_first_nz <= first_nz_n;
        out_nz_count <= nz_count_n;
        out_len      <= idx_n;
        out_ovf      <= ovf_n;
        all_zero     <= 1'b1;
        seen         <= 1'b0;
        ovf          <= 1'b0;
        idx          <= '0;
        first_nz     <= '0;
        nz_count     <= '0;
      end else begin
        all_zero <= all_zero_n;
        seen     <= seen_n;
        ovf      <= ovf_n;
        idx      <= idx_n;
        first_nz <= first_nz_n;
        nz_count <= nz_count_n;
      end
    end
  end

endmodule

// File: tb/tb_zero_scan_stream.sv
// Directed bench: 32-bit/8-bit instance and a 3-bit-count instance share one
// stream; a 1-bit-wide instance is driven separately with idle gaps.
module tb_zero_scan_stream;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [31:0] in_data = '0;

  logic       a_in_ready, a_out_valid, a_out_zero, a_out_ovf;
  logic [7:0] a_out_first_nz, a_out_nz_count, a_out_len;
  logic       b_in_ready, b_out_valid, b_out_zero, b_out_ovf;
  logic [2:0] b_out_first_nz, b_out_nz_count, b_out_len;

  logic       c_in_valid = 1'b0, c_in_last = 1'b0, c_out_ready = 1'b0;
  logic [0:0] c_in_data = '0;
  logic       c_in_ready, c_out_valid, c_out_zero, c_out_ovf;
  logic [7:0] c_out_first_nz, c_out_nz_count, c_out_len;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  zero_scan_stream #(.WIDTH(32), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_zero(a_out_zero), .out_first_nz(a_out_first_nz),
    .out_nz_count(a_out_nz_count), .out_len(a_out_len), .out_ovf(a_out_ovf));

  zero_scan_stream #(.WIDTH(32), .CNT_W(3)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_zero(b_out_zero), .out_first_nz(b_out_first_nz),
    .out_nz_count(b_out_nz_count), .out_len(b_out_len), .out_ovf(b_out_ovf));

  zero_scan_stream #(.WIDTH(1), .CNT_W(8)) dut_c (
    .clk(clk), .reset(reset), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .in_last(c_in_last), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .out_zero(c_out_zero), .out_first_nz(c_out_first_nz),
    .out_nz_count(c_out_nz_count), .out_len(c_out_len), .out_ovf(c_out_ovf));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic c_send(input logic d, input logic l);
    int gap;
    gap = $urandom_range(3, 0);
    for (int i = 0; i < gap; i++) tick();
    c_in_valid   = 1'b1;
    c_in_data[0] = d;
    c_in_last    = l;
    tick();
    c_in_valid = 1'b0;
    c_in_last  = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    chk("rst_out_valid", {31'b0, a_out_valid}, 0);
    chk("rst_in_ready",  {31'b0, a_in_ready}, 1);
    chk("rst_out_zero",  {31'b0, a_out_zero}, 0);
    chk("rst_out_len",   {24'b0, a_out_len}, 0);

    // Single zero word
    send(32'h0, 1'b1);
    chk("t1_out_valid", {31'b0, a_out_valid}, 1);
    chk("t1_in_ready",  {31'b0, a_in_ready}, 0);
    chk("t1_zero",      {31'b0, a_out_zero}, 1);
    chk("t1_first_nz",  {24'b0, a_out_first_nz}, 0);
    chk("t1_nz_count",  {24'b0, a_out_nz_count}, 0);
    chk("t1_len",       {24'b0, a_out_len}, 1);
    chk("t1_ovf",       {31'b0, a_out_ovf}, 0);
    release_result();

    // Four-word frame with two non-zero words
    send(32'h0, 1'b0);
    send(32'h0, 1'b0);
    send(32'h0000_0100, 1'b0);
    send(32'h8000_0000, 1'b1);
    chk("t2_zero",     {31'b0, a_out_zero}, 0);
    chk("t2_first_nz", {24'b0, a_out_first_nz}, 2);
    chk("t2_nz_count", {24'b0, a_out_nz_count}, 2);
    chk("t2_len",      {24'b0, a_out_len}, 4);

    // Backpressure: result held, no input accepted
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", {31'b0, a_out_valid}, 1);
      chk("bp_in_ready",  {31'b0, a_in_ready}, 0);
      chk("bp_len",       {24'b0, a_out_len}, 4);
      chk("bp_first_nz",  {24'b0, a_out_first_nz}, 2);
      tick();
    end
    release_result();
    chk("bp_rel_in_ready",  {31'b0, a_in_ready}, 1);
    chk("bp_rel_out_valid", {31'b0, a_out_valid}, 0);

    send(32'h1, 1'b1);
    chk("t3_zero",     {31'b0, a_out_zero}, 0);
    chk("t3_first_nz", {24'b0, a_out_first_nz}, 0);
    chk("t3_nz_count", {24'b0, a_out_nz_count}, 1);
    chk("t3_len",      {24'b0, a_out_len}, 1);
    release_result();

    // Saturation: ten zeros then a one
    for (int i = 0; i < 10; i++) send(32'h0, 1'b0);
    send(32'h1, 1'b1);
    chk("sat_b_len",      {29'b0, b_out_len}, 7);
    chk("sat_b_ovf",      {31'b0, b_out_ovf}, 1);
    chk("sat_b_zero",     {31'b0, b_out_zero}, 0);
    chk("sat_b_first_nz", {29'b0, b_out_first_nz}, 7);
    chk("sat_b_nz_count", {29'b0, b_out_nz_count}, 1);
    chk("sat_a_len",      {24'b0, a_out_len}, 11);
    chk("sat_a_ovf",      {31'b0, a_out_ovf}, 0);
    chk("sat_a_first_nz", {24'b0, a_out_first_nz}, 10);
    release_result();

    // Reset mid-frame discards partial accumulation
    send(32'h5, 1'b0);
    send(32'h6, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_out_valid", {31'b0, a_out_valid}, 0);
    chk("mid_rst_in_ready",  {31'b0, a_in_ready}, 1);
    send(32'h0, 1'b1);
    chk("mid_rst_zero",     {31'b0, a_out_zero}, 1);
    chk("mid_rst_len",      {24'b0, a_out_len}, 1);
    chk("mid_rst_nz_count", {24'b0, a_out_nz_count}, 0);

    // Reset while a result is pending
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("done_rst_out_valid", {31'b0, a_out_valid}, 0);
    chk("done_rst_len",       {24'b0, a_out_len}, 0);

    // One-bit words with idle gaps
    c_send(1'b0, 1'b0);
    c_send(1'b1, 1'b0);
    c_send(1'b0, 1'b1);
    chk("w1_out_valid", {31'b0, c_out_valid}, 1);
    chk("w1_zero",      {31'b0, c_out_zero}, 0);
    chk("w1_first_nz",  {24'b0, c_out_first_nz}, 1);
    chk("w1_nz_count",  {24'b0, c_out_nz_count}, 1);
    chk("w1_len",       {24'b0, c_out_len}, 3);
    c_out_ready = 1'b1;
    tick();
    c_out_ready = 1'b0;
    chk("w1_rel_in_ready", {31'b0, c_in_ready}, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/zero_scan_stream.md
# zero_scan_stream

Parametrised, sequential successor to the single-word zero detector. It consumes a framed stream of WIDTH-bit words over a valid/ready handshake. For each frame it reports whether every word was zero, the index of the first non-zero word, the count of non-zero words and the frame length. It sits behind the ALU result bus, feeding branch/compare logic and the memory-clear checker.

## Interface
Parameters:
- WIDTH, 32, data word width in bits (≥1)
- CNT_W, 8, width of index/count outputs; max representable value 2^CNT_W−1

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; clears all state
- in_valid  input  1  in_data/in_last valid this cycle
- in_ready  output  1  block can accept a word this cycle
- in_data  input  WIDTH  data word
- in_last  input  1  final word of current frame
- out_valid  output  1  frame result valid
- out_ready  input  1  downstream accepts result
- out_zero  output  1  1 iff every word of the frame was all-zero
- out_first_nz  output  CNT_W  index (0-based) of first non-zero word; 0 when out_zero=1
- out_nz_count  output  CNT_W  number of non-zero words, saturating
- out_len  output  CNT_W  number of words in frame, saturating
- out_ovf  output  1  frame exceeded 2^CNT_W−1 words (len/count/index saturated)

## Operation
- Per-word test: word_zero = NOR-reduction of all WIDTH bits of in_data.
- FSM with two states:
  - ACC: in_ready=1, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Beat accepted when in_valid && in_ready.
- ACC, accepted beat with in_last=0, running accumulators update:
  - all_zero &= word_zero.
  - If word is non-zero and no non-zero seen yet: first_nz ← idx, seen ← 1.
  - nz_count += !word_zero, saturating.
  - idx += 1, saturating. ovf set if idx already at max.
- ACC, accepted beat with in_last=1: the final word is folded in using the same rules. Results are then registered to the out_* regs and the FSM moves to DONE. Accumulators are cleared at the same time: all_zero=1, seen=0, idx=0, nz_count=0, ovf=0.
- Length rule: out_len = idx+1, saturating at max. ovf is also set if idx+1 would exceed max.
- Single-word frame (first beat has in_last=1) is legal: out_len=1.
- DONE: out_* held stable until out_valid && out_ready, then back to ACC. out_* retain their values, but out_valid=0 and they are don't-care.
- in_valid while in ACC without a frame start needs no special handling; any accepted word starts or continues a frame.
- Saturation: once idx reaches 2^CNT_W−1 it stops incrementing. out_first_nz may still be valid if the first non-zero word arrived before saturation. If the first non-zero word arrives after saturation, first_nz = max.
- reset: FSM→ACC, accumulators cleared, all out_* = 0, out_valid=0, in_ready=1 on the cycle after reset is sampled. Reset mid-frame discards the partial frame. Reset in DONE discards the pending result.

## Timing
- Throughput in ACC: one word per cycle.
- Latency: out_valid asserts the cycle after the in_last beat is accepted.
- Inter-frame bubble: minimum one cycle. in_ready=0 for every cycle in DONE, and returns to 1 the cycle after the out handshake.
- out_valid never drops without out_ready, except on reset.
- in_ready depends only on state, not on in_valid or out_ready (no combinational path).
- All outputs are registered.

## Test plan
- Reset then single word 32'h0000_0000 with last → next cycle out_valid=1, out_zero=1, out_first_nz=0, out_nz_count=0, out_len=1, out_ovf=0.
- Frame of 4 words {0, 0, 32'h0000_0100, 32'h8000_0000} → out_zero=0, out_first_nz=2, out_nz_count=2, out_len=4.
- Backpressure: hold out_ready=0 for 5 cycles after result → out_* stable, in_ready=0 throughout. Assert out_ready → in_ready=1 the next cycle. A second frame {32'h1} gives out_first_nz=0, out_nz_count=1, out_len=1.
- CNT_W=3, frame of 10 zero words then 32'h1 with last → out_len=7, out_ovf=1, out_zero=0, out_first_nz=7, out_nz_count=1.
- Reset asserted after 2 non-zero words of a frame, then frame {0} → out_zero=1, out_len=1 (no stale state).
- WIDTH=1 instance, frame {1'b0, 1'b1, 1'b0} with random in_valid gaps → out_first_nz=1, out_nz_count=1, out_len=3.
